// File: rtl/led_fade_if.sv
// led_fade_if: pattern/LED bundle between the sequencer core and the fade driver.
//   patternIn[7:0] : pattern from the sequencer core
//   fadeEn         : 1 = crossfade on change, 0 = pass-through
//   ledOut[7:0]    : registered LED drive
//   busy           : registered, high while a fade is running
// master = pattern source / LED consumer, slave = led_fade_driver.
interface led_fade_if;
  logic [7:0] patternIn;
  logic       fadeEn;
  logic [7:0] ledOut;
  logic       busy;

  modport master (output patternIn, fadeEn, input ledOut, busy);
  modport slave  (input patternIn, fadeEn, output ledOut, busy);
endinterface

// File: rtl/led_fade_driver.sv
// led_fade_driver: crossfades the board LEDs from the displayed pattern to each
// new pattern using per-bit PWM; with fading disabled it is a fixed-latency
// pass-through.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : led_fade_if.slave (patternIn, fadeEn in; ledOut, busy out)
// Parameters:
//   PWM_BITS : PWM counter width; period and level count are 2^PWM_BITS
//   HOLD     : PWM periods spent at each fade level (>= 1)
module led_fade_driver #(
  parameter int PWM_BITS = 4,
  parameter int HOLD     = 256
) (
  input  logic       clk,
  input  logic       rst,
  led_fade_if.slave  bus
);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PWM_BITS-1:0] PMAX  = '1;
  localparam logic [HW-1:0]       HLAST = HW'(HOLD - 1);

  typedef enum logic {IDLE, FADE} state_t;

  state_t              state, state_nx;
  logic [7:0]          cur_pat, cur_nx;
  logic [7:0]          tgt_pat, tgt_nx;
  logic [7:0]          led_nx;
  logic [PWM_BITS-1:0] level, level_nx;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_nx;
  logic [HW-1:0]       hold_cnt, hold_nx;

  always_comb begin
    state_nx = state;
    cur_nx   = cur_pat;
    tgt_nx   = tgt_pat;
    level_nx = level;
    pwm_nx   = pwm_cnt;
    hold_nx  = hold_cnt;
    led_nx   = cur_pat;
    case (state)
      IDLE: begin
        if (bus.patternIn != cur_pat) begin
          if (bus.fadeEn) begin
            tgt_nx   = bus.patternIn;
            level_nx = '0;
            pwm_nx   = '0;
            hold_nx  = '0;
            state_nx = FADE;
          end else begin
            cur_nx = bus.patternIn;
          end
        end
      end
      FADE: begin
        if (!bus.fadeEn) begin
          // abort: snap straight to the destination
          cur_nx   = tgt_pat;
          led_nx   = tgt_pat;
          state_nx = IDLE;
        end else begin
          // bits equal in both patterns are unaffected by the selection, so
          // choosing the whole target vector during the "on" phase is exact
          led_nx = (pwm_cnt < level) ? tgt_pat : cur_pat;
          pwm_nx = pwm_cnt + 1'b1;
          if (pwm_cnt == PMAX) begin
            if (hold_cnt == HLAST) begin
              hold_nx  = '0;
              level_nx = level + 1'b1;
              // last period of the top level: hand over to the target
              if (level == PMAX) begin
                cur_nx   = tgt_pat;
                state_nx = IDLE;
              end
            end else begin
              hold_nx = hold_cnt + 1'b1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_pat    <= '0;
      tgt_pat    <= '0;
      level      <= '0;
      pwm_cnt    <= '0;
      hold_cnt   <= '0;
      bus.ledOut <= '0;
      bus.busy   <= 1'b0;
    end else begin
      state      <= state_nx;
      cur_pat    <= cur_nx;
      tgt_pat    <= tgt_nx;
      level      <= level_nx;
      pwm_cnt    <= pwm_nx;
      hold_cnt   <= hold_nx;
      bus.ledOut <= led_nx;
      bus.busy   <= (state_nx == FADE);
    end
  end
endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: scoreboard bench. Each stimulus step pushes the per-edge
// expected (ledOut, busy) sequence derived from the closed-form fade timing;
// tick() pops one entry per clock edge and compares. dut1: PWM_BITS=4 HOLD=1,
// dut3: PWM_BITS=4 HOLD=3.
module tb_led_fade_driver;
  typedef struct packed {
    logic [7:0] led;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_fade_if b1();
  led_fade_if b3();

  led_fade_driver #(.PWM_BITS(4), .HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  led_fade_driver #(.PWM_BITS(4), .HOLD(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  exp_t  q1[$];
  exp_t  q3[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    busy1_n = 0;
  int    busy3_n = 0;
  int    led0_n = 0;
  logic  prev_busy1 = 1'b0;
  string phase = "init";

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  task automatic push(input int sel, input logic [7:0] led, input logic bsy);
    exp_t e;
    e.led  = led;
    e.busy = bsy;
    if (sel == 3) q3.push_back(e);
    else          q1.push_back(e);
  endtask

  // Fade a->b sampled at edge k: edge k shows a with busy up; FADE cycle j
  // (edge k+1+j) shows b only while phase j%16 < level j/(16*hold).
  // busy drops on the edge of the last FADE cycle. n limits the cycles pushed.
  task automatic push_fade(input int sel, input logic [7:0] a, input logic [7:0] b,
                           input int hold, input int n);
    int full;
    full = 256 * hold;
    push(sel, a, 1'b1);
    for (int j = 0; j < n; j++)
      push(sel, ((j % 16) < (j / (16 * hold))) ? b : a, (j != full - 1));
  endtask

  task automatic push_idle(input int sel, input logic [7:0] v, input int n);
    for (int j = 0; j < n; j++) push(sel, v, 1'b0);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk({phase, "/led"}, b1.ledOut, e.led);
      chk({phase, "/busy"}, b1.busy, e.busy);
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk({phase, "/led3"}, b3.ledOut, e.led);
      chk({phase, "/busy3"}, b3.busy, e.busy);
    end
    if (b1.busy) busy1_n++;
    if (b3.busy) busy3_n++;
    if (prev_busy1 && b1.ledOut[0]) led0_n++;
    prev_busy1 = b1.busy;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    b1.patternIn = 8'hA5;
    b1.fadeEn    = 1'b0;
    b3.patternIn = 8'h00;
    b3.fadeEn    = 1'b0;

    // reset state
    #12;
    chk("rst/led", b1.ledOut, 8'h00);
    chk("rst/busy", b1.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    phase = "pass_a5";
    push(1, 8'h00, 1'b0);
    push(1, 8'hA5, 1'b0);
    ticks(2);

    // asynchronous reset in the middle of a fade
    phase = "pre_rst";
    b1.fadeEn    = 1'b1;
    b1.patternIn = 8'h5A;
    push_fade(1, 8'hA5, 8'h5A, 1, 10);
    ticks(11);
    b1.patternIn = 8'hA5;
    #2 rst = 1'b1;
    #1;
    chk("async_rst/led", b1.ledOut, 8'h00);
    chk("async_rst/busy", b1.busy, 0);
    b1.fadeEn = 1'b0;
    tick();
    rst = 1'b0;
    phase = "post_rst";
    push(1, 8'h00, 1'b0);
    push(1, 8'hA5, 1'b0);
    ticks(2);

    // full fade 00 -> FF
    phase = "to00";
    b1.patternIn = 8'h00;
    push_idle(1, 8'hA5, 1);
    push(1, 8'h00, 1'b0);
    ticks(2);
    phase = "full";
    busy1_n = 0;
    led0_n  = 0;
    b1.fadeEn    = 1'b1;
    b1.patternIn = 8'hFF;
    push_fade(1, 8'h00, 8'hFF, 1, 256);
    ticks(257);
    push_idle(1, 8'hFF, 3);
    ticks(3);
    chk("full/busy_cycles", busy1_n, 256);
    chk("full/bit0_high", led0_n, 120);

    // partial-difference fade 0F -> 3C
    phase = "to0f";
    b1.fadeEn    = 1'b0;
    b1.patternIn = 8'h0F;
    push_idle(1, 8'hFF, 1);
    push(1, 8'h0F, 1'b0);
    ticks(2);
    phase = "partial";
    b1.fadeEn    = 1'b1;
    b1.patternIn = 8'h3C;
    push_fade(1, 8'h0F, 8'h3C, 1, 256);
    ticks(257);
    push_idle(1, 8'h3C, 2);
    ticks(2);
    chk("partial/final", b1.ledOut, 8'h3C);

    // pattern change while fading is deferred until the fade ends
    phase = "to00b";
    b1.fadeEn    = 1'b0;
    b1.patternIn = 8'h00;
    push_idle(1, 8'h3C, 1);
    push(1, 8'h00, 1'b0);
    ticks(2);
    phase = "change";
    busy1_n = 0;
    b1.fadeEn    = 1'b1;
    b1.patternIn = 8'hF0;
    push_fade(1, 8'h00, 8'hF0, 1, 256);
    ticks(101);
    b1.patternIn = 8'h0F;
    push_fade(1, 8'hF0, 8'h0F, 1, 256);
    ticks(156 + 257);
    push_idle(1, 8'h0F, 2);
    ticks(2);
    chk("change/busy_cycles", busy1_n, 512);

    // abort by dropping fadeEn
    phase = "to00c";
    b1.fadeEn    = 1'b0;
    b1.patternIn = 8'h00;
    push_idle(1, 8'h0F, 1);
    push(1, 8'h00, 1'b0);
    ticks(2);
    phase = "abort";
    b1.fadeEn    = 1'b1;
    b1.patternIn = 8'h81;
    push_fade(1, 8'h00, 8'h81, 1, 50);
    ticks(51);
    b1.fadeEn = 1'b0;
    push_idle(1, 8'h81, 3);
    ticks(3);

    // HOLD=3: each level held 48 cycles
    phase = "hold3";
    busy3_n = 0;
    b3.fadeEn    = 1'b1;
    b3.patternIn = 8'h01;
    push_fade(3, 8'h00, 8'h01, 3, 768);
    ticks(769);
    push_idle(3, 8'h01, 2);
    ticks(2);
    chk("hold3/busy_cycles", busy3_n, 768);

    chk("sb_drain", q1.size() + q3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
